// File: rtl/shift_pkg.sv
// Shared encodings for the shift sequencer: operation codes, FSM states and widths.
package shift_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 3;

  localparam logic [OP_W-1:0] OP_LSL = 4'b0001;
  localparam logic [OP_W-1:0] OP_LSR = 4'b0010;
  localparam logic [OP_W-1:0] OP_CIR = 4'b0011;
  localparam logic [OP_W-1:0] OP_CIL = 4'b0100;
  localparam logic [OP_W-1:0] OP_ASR = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shifter.sv
// One single-bit step of the selected shift/rotate on an 8-bit value; purely combinational.
module shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] i_acc,
  input  logic [OP_W-1:0]   i_op,
  output logic [DATA_W-1:0] o_result
);

  always_comb begin
    o_result = i_acc;
    case (i_op)
      OP_LSL:  o_result = {i_acc[DATA_W-2:0], 1'b0};
      OP_LSR:  o_result = {1'b0, i_acc[DATA_W-1:1]};
      OP_CIR:  o_result = {i_acc[0], i_acc[DATA_W-1:1]};
      OP_CIL:  o_result = {i_acc[DATA_W-2:0], i_acc[DATA_W-1]};
      OP_ASR:  o_result = {i_acc[DATA_W-1], i_acc[DATA_W-1:1]};
      // Unknown codes leave the value untouched but still cost a step.
      default: o_result = i_acc;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-step shift sequencer: latches an operand, applies 'amount' single-bit steps of the
// latched op, then pulses done. Abort cancels a running operation without a done pulse.
module shift_sequencer
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [CNT_W-1:0]  amount,
  input  logic [DATA_W-1:0] data_in,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out
);

  state_t            r_state;
  logic [DATA_W-1:0] r_acc;
  logic [OP_W-1:0]   r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] w_step;

  shifter u_shifter (
    .i_acc    (r_acc),
    .i_op     (r_op),
    .o_result (w_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc  <= data_in;
            r_op   <= op;
            r_cnt  <= amount;
            r_busy <= 1'b1;
            if (amount == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          // The step of the current cycle still lands on an abort edge; only sequencing stops.
          r_acc <= w_step;
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed results, latencies, abort and reset cases.
module tb_shift_sequencer;
  import shift_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] op;
  logic [2:0] amount;
  logic [7:0] data_in;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] data_out;

  int n_total;
  int n_pass;

  shift_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .amount   (amount),
    .data_in  (data_in),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
      $display("check %s: got 0x%0h", tag, obs);
    end else begin
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one start, wait (bounded) for done, check latency, busy length and result.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [2:0] amt,
                        input logic [7:0] din, input logic [7:0] exp_data);
    int lat;
    int busy_cycles;
    start   = 1'b1;
    op      = o;
    amount  = amt;
    data_in = din;
    tick();
    start   = 1'b0;
    lat = 99;
    busy_cycles = 0;
    for (int i = 1; i <= 12; i++) begin
      busy_cycles += int'(busy);
      if (done) begin
        lat = i;
        break;
      end
      tick();
    end
    check({tag, "_latency"}, lat, int'(amt) + 1);
    check({tag, "_busy_cycles"}, busy_cycles, int'(amt) + 1);
    check({tag, "_data"}, data_out, exp_data);
    tick();
    check({tag, "_idle_after"}, {busy, done}, 2'b00);
  endtask

  task automatic watch_no_done(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      seen |= done;
      tick();
    end
    check(tag, seen, 1'b0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b1;
    start   = 1'b0;
    op      = 4'b0000;
    amount  = 3'd0;
    data_in = 8'h00;
    abort   = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_outputs", {busy, done, data_out}, 10'h000);
    #19 rst_n = 1'b1;

    // Accepted on the first edge after release.
    run_op("lsl3", OP_LSL, 3'd3, 8'h81, 8'h08);
    run_op("asr7", OP_ASR, 3'd7, 8'h80, 8'hFF);
    run_op("cir1", OP_CIR, 3'd1, 8'h01, 8'h80);

    // amount=0 with abort held: abort ignored in IDLE and DONE.
    abort = 1'b1;
    run_op("cil0", OP_CIL, 3'd0, 8'h5A, 8'h5A);
    abort = 1'b0;
    run_op("nop2", 4'b1111, 3'd2, 8'hA5, 8'hA5);
    run_op("cil3", OP_CIL, 3'd3, 8'h96, 8'hB4);

    // Start pulse while busy is ignored, and start held during DONE is ignored too.
    start = 1'b1; op = OP_LSR; amount = 3'd5; data_in = 8'hF0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op = OP_LSL; amount = 3'd1; data_in = 8'h11;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10 && !done; i++) tick();
    check("lsr5_done", done, 1'b1);
    check("lsr5_data", data_out, 8'h07);
    start = 1'b1; op = OP_CIL; amount = 3'd0; data_in = 8'h33;
    tick();
    start = 1'b0;
    check("start_in_done_ignored", {busy, done, data_out}, {2'b00, 8'h07});
    tick();
    check("idle_holds", data_out, 8'h07);

    // Abort in the 2nd SHIFT cycle.
    start = 1'b1; op = OP_LSL; amount = 3'd6; data_in = 8'h01;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_state", {busy, done, data_out}, {2'b00, 8'h04});
    watch_no_done("abort_no_done", 8);
    check("abort_hold", data_out, 8'h04);

    // Abort wins over counter expiry.
    start = 1'b1; op = OP_LSL; amount = 3'd1; data_in = 8'h01;
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_prio_state", {busy, done, data_out}, {2'b00, 8'h02});
    watch_no_done("abort_prio_no_done", 4);

    // Asynchronous reset mid-SHIFT.
    start = 1'b1; op = OP_LSL; amount = 3'd5; data_in = 8'hFF;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, data_out}, 10'h000);
    tick();
    #3 rst_n = 1'b1;
    watch_no_done("reset_no_done", 6);
    check("reset_data_held", data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    run_op("after_reset_cir", OP_CIR, 3'd1, 8'h01, 8'h80);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

endmodule
